// File: rtl/pong_vga_pkg.sv
// Shared 640x480@60 VGA timing constants, clear-FSM encodings and frame-buffer address helper.
package pong_vga_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int unsigned ADDR_W = 15;

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  function automatic logic [ADDR_W-1:0] fb_addr(input int unsigned x, input int unsigned y,
                                                input int unsigned width);
    return ADDR_W'(y * width + x);
  endfunction

endpackage

// File: rtl/pixel_ram.sv
// Simple dual-port pixel store: one write port, one registered read port (1-cycle latency).
// A read colliding with a write to the same address returns the old contents.
module pixel_ram #(
  parameter int unsigned DEPTH  = 19200,
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 3
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/frame_buffer_scanout.sv
// 160x120x3 frame buffer with 4x-scaled 640x480 VGA scanout; outputs lag the counters by 1 cycle.
// Writes take one cycle with no backpressure; they are dropped until the post-reset clear finishes.
module frame_buffer_scanout
  import pong_vga_pkg::*;
#(
  parameter logic [2:0]  BACKGROUND_COLOUR = 3'd0,
  parameter int unsigned FB_WIDTH          = 160,
  parameter int unsigned FB_HEIGHT         = 120
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] vga_x,
  input  logic [6:0] vga_y,
  input  logic       plot,
  input  logic [2:0] colour,
  output logic       ready,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic [2:0] vga_colour
);

  localparam int unsigned FB_SIZE = FB_WIDTH * FB_HEIGHT;

  logic [0:0]        state;
  logic [ADDR_W-1:0] clear_addr;
  logic [9:0]        h_count;
  logic [9:0]        v_count;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] raddr;
  logic [2:0]        wdata;
  logic [2:0]        rdata;
  logic              visible;
  logic              hs_raw;
  logic              vs_raw;

  assign ready = (state == S_RUN);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_CLEAR;
      clear_addr <= '0;
    end else if (state == S_CLEAR) begin
      clear_addr <= clear_addr + 1'b1;
      if (clear_addr == ADDR_W'(FB_SIZE - 1)) state <= S_RUN;
    end
  end

  // The clear owns the write port until it completes; plots are ignored meanwhile.
  always_comb begin
    we    = 1'b0;
    waddr = clear_addr;
    wdata = BACKGROUND_COLOUR;
    if (reset) begin
      we = 1'b0;
    end else if (state == S_CLEAR) begin
      we = 1'b1;
    end else if (plot && (32'(vga_x) < FB_WIDTH) && (32'(vga_y) < FB_HEIGHT)) begin
      we    = 1'b1;
      waddr = fb_addr(32'(vga_x), 32'(vga_y), FB_WIDTH);
      wdata = colour;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      h_count <= '0;
      v_count <= '0;
    end else if (h_count == 10'(H_TOTAL - 1)) begin
      h_count <= '0;
      v_count <= (v_count == 10'(V_TOTAL - 1)) ? 10'd0 : v_count + 1'b1;
    end else begin
      h_count <= h_count + 1'b1;
    end
  end

  assign visible = (h_count < 10'(H_VISIBLE)) && (v_count < 10'(V_VISIBLE));
  assign hs_raw  = !((h_count >= 10'(H_VISIBLE + H_FRONT)) &&
                     (h_count <  10'(H_VISIBLE + H_FRONT + H_SYNC)));
  assign vs_raw  = !((v_count >= 10'(V_VISIBLE + V_FRONT)) &&
                     (v_count <  10'(V_VISIBLE + V_FRONT + V_SYNC)));
  // Dropping the low two counter bits replicates each stored pixel over a 4x4 screen block.
  assign raddr   = visible ? fb_addr(32'(h_count[9:2]), 32'(v_count[9:2]), FB_WIDTH) : '0;

  pixel_ram #(
    .DEPTH (FB_SIZE),
    .ADDR_W(ADDR_W),
    .DATA_W(3)
  ) u_pixel_ram (
    .clock(clock),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(raddr),
    .rdata(rdata)
  );

  // Sync/blank take one register stage to line up with the RAM read data.
  always_ff @(posedge clock) begin
    if (reset) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
    end else begin
      vga_hs      <= hs_raw;
      vga_vs      <= vs_raw;
      vga_blank_n <= visible;
    end
  end

  assign vga_colour = vga_blank_n ? rdata : 3'd0;

endmodule

// File: tb/tb_frame_buffer_scanout.sv
// Randomized plots against a pixel-array model; scanout expectations derived from cycle position.
module tb_frame_buffer_scanout;

  localparam logic [2:0] BG = 3'd2;
  localparam int CLEAR_CYCLES = 19200;
  localparam int RUN_CYCLES   = 72000;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] vga_x = '0;
  logic [6:0] vga_y = '0;
  logic       plot  = 1'b0;
  logic [2:0] colour = '0;
  logic       ready;
  logic       vga_hs;
  logic       vga_vs;
  logic       vga_blank_n;
  logic [2:0] vga_colour;

  frame_buffer_scanout #(
    .BACKGROUND_COLOUR(BG)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .plot       (plot),
    .colour     (colour),
    .ready      (ready),
    .vga_hs     (vga_hs),
    .vga_vs     (vga_vs),
    .vga_blank_n(vga_blank_n),
    .vga_colour (vga_colour)
  );

  always #20 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  logic [2:0] fb_m    [CLEAR_CYCLES];
  bit         known_m [CLEAR_CYCLES];

  int k = 0;
  bit prev_hs = 1'b1;
  bit prev_ready = 1'b0;
  int first_fall = -1;
  int last_fall = -1;

  int dir_x [8] = '{0, 159, 160, 0, 200, 159, 0, 5};
  int dir_y [8] = '{8, 8, 9, 120, 10, 21, 21, 12};
  int dir_c [8] = '{5, 3, 7, 7, 7, 1, 4, 6};

  int spot_h [15] = '{0, 3, 4, 636, 639, 632, 0, 160, 40, 100, 100, 20, 24, 636, 0};
  int spot_v [15] = '{32, 35, 32, 32, 35, 35, 40, 44, 40, 30, 31, 48, 48, 84, 84};
  int spot_e [15] = '{5, 5, 2, 3, 3, 2, 2, 2, 2, 2, 5, 6, 2, 1, 4};

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, k, got, exp);
    end
  endtask

  task automatic tick(input bit rst, input bit pl, input int x, input int y, input int c);
    int p, h, v, a, kb;
    bit vis, exp_hs, exp_vs;
    reset  = rst;
    plot   = pl;
    vga_x  = 8'(x);
    vga_y  = 7'(y);
    colour = 3'(c);
    kb = k;
    @(posedge clock);
    #1;
    if (rst) begin
      k = 0;
      check("rst_sync", int'({vga_hs, vga_vs, vga_blank_n}), 6);
      check("rst_colour", int'(vga_colour), 0);
      check("rst_ready", int'(ready), 0);
      prev_hs = 1'b1;
      prev_ready = 1'b0;
      first_fall = -1;
      last_fall = -1;
    end else begin
      k = kb + 1;
      p = k - 1;
      h = p % 800;
      v = (p / 800) % 525;
      vis = (h < 640) && (v < 480);
      exp_hs = !((h >= 656) && (h < 752));
      exp_vs = !((v >= 490) && (v < 492));
      check("sync", int'({vga_hs, vga_vs, vga_blank_n}), int'({exp_hs, exp_vs, vis}));
      if (!vis) begin
        check("blank_colour", int'(vga_colour), 0);
      end else begin
        a = (v / 4) * 160 + h / 4;
        if (known_m[a]) check("pixel", int'(vga_colour), int'(fb_m[a]));
      end
      check("ready", int'(ready), (k >= CLEAR_CYCLES) ? 1 : 0);
      for (int s = 0; s < 15; s++)
        if (h == spot_h[s] && v == spot_v[s]) check("spot", int'(vga_colour), spot_e[s]);
      if (prev_hs && !vga_hs) begin
        if (first_fall < 0) first_fall = k;
        else check("hs_period", k - last_fall, 800);
        last_fall = k;
      end
      if (!prev_hs && vga_hs && last_fall >= 0) check("hs_low", k - last_fall, 96);
      prev_hs = vga_hs;
      if (!prev_ready && ready) check("ready_rise", k, CLEAR_CYCLES);
      prev_ready = ready;
      if (k <= CLEAR_CYCLES) begin
        fb_m[k-1] = BG;
        known_m[k-1] = 1'b1;
      end
      if (kb >= CLEAR_CYCLES && pl && x < 160 && y < 120) begin
        fb_m[y*160 + x] = 3'(c);
        known_m[y*160 + x] = 1'b1;
      end
    end
    @(negedge clock);
  endtask

  task automatic random_tick();
    int rx, ry;
    rx = int'($urandom_range(0, 199));
    ry = ($urandom_range(0, 1) == 0) ? int'($urandom_range(13, 20)) : int'($urandom_range(100, 127));
    tick(1'b0, $urandom_range(0, 3) == 0, rx, ry, int'($urandom_range(0, 7)));
  endtask

  initial begin
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 0, 0, 0);
    for (int i = 0; i < 5000; i++) random_tick();
    tick(1'b1, 1'b0, 0, 0, 0);
    while (k < RUN_CYCLES) begin
      if (k == 99)
        tick(1'b0, 1'b1, 10, 10, 7);
      else if (k >= CLEAR_CYCLES && k < CLEAR_CYCLES + 8)
        tick(1'b0, 1'b1, dir_x[k-CLEAR_CYCLES], dir_y[k-CLEAR_CYCLES], dir_c[k-CLEAR_CYCLES]);
      else if (k == 24100)
        tick(1'b0, 1'b1, 25, 7, 5);
      else
        random_tick();
    end
    check("hs_first_fall", first_fall, 657);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
